// File: rtl/matrix_mode_hub.sv
// matrix_mode_hub: key debounce, NEXT/PREV mode stepping with a blanking gap between modes,
// and a registered row/column mux that forwards only the active mode's pattern to the board.
module matrix_mode_hub #(
  parameter int unsigned ROWS         = 5,
  parameter int unsigned COLS         = 7,
  parameter int unsigned NUM_KEYS     = 7,
  parameter int unsigned NUM_MODES    = 4,
  parameter int unsigned LED_W        = 8,
  parameter int unsigned NEXT_KEY     = 6,
  parameter int unsigned PREV_KEY     = 5,
  parameter int unsigned DEBOUNCE_CYC = 1000000,
  parameter int unsigned BLANK_CYC    = 50000,
  localparam int unsigned MW          = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic                      CLOCK_50,
  input  logic                      rst_n,
  input  logic [NUM_KEYS-1:0]       keys,
  input  logic [NUM_MODES*ROWS-1:0] mode_row_in,
  input  logic [NUM_MODES*COLS-1:0] mode_col_in,
  output logic [NUM_KEYS-1:0]       keys_db,
  output logic [NUM_MODES-1:0]      enable,
  output logic [MW-1:0]             mode,
  output logic [ROWS-1:0]           row,
  output logic [COLS-1:0]           column,
  output logic [LED_W-1:0]          leds
);

  // Counter widths; a 1-cycle setting still needs a 1-bit counter.
  localparam int unsigned CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYC - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYC - 1);
  localparam logic [MW-1:0] LAST_MODE  = MW'(NUM_MODES - 1);

  typedef enum logic [0:0] {
    StRun,
    StBlank
  } state_e;

  // Input synchroniser and debounce state
  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_keys_db;
  logic [CW-1:0]       r_db_cnt [NUM_KEYS];
  logic                r_next_pulse;
  logic                r_prev_pulse;

  // Mode FSM and registered board outputs
  state_e              r_state;
  logic [MW-1:0]       r_mode;
  logic [MW-1:0]       r_pending;
  logic [BW-1:0]       r_blank_cnt;
  logic [NUM_MODES-1:0] r_enable;
  logic [LED_W-1:0]    r_leds;
  logic [ROWS-1:0]     r_row;
  logic [COLS-1:0]     r_col;

  // Combinational helpers
  logic [NUM_KEYS-1:0] w_key_lvl;
  logic [NUM_KEYS-1:0] w_db_done;
  logic                w_step;
  logic [MW-1:0]       w_next_mode;
  logic [MW-1:0]       w_prev_mode;
  logic [ROWS-1:0]     w_sel_row;
  logic [COLS-1:0]     w_sel_col;
  logic [NUM_MODES-1:0] w_pend_en;
  logic [LED_W-1:0]    w_pend_leds;

  // Two-stage synchroniser; released (high) keys are the reset level so no press is seen at boot.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= keys;
      r_sync2 <= r_sync1;
    end
  end

  // Keys are active-low on the pins; the debouncer works on pressed = 1.
  always_comb begin
    w_key_lvl = ~r_sync2;
  end

  // A key's debounce completes when it has disagreed with its accepted level for the full window.
  always_comb begin
    w_db_done = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_db_done[k] = (w_key_lvl[k] != r_keys_db[k]) && (r_db_cnt[k] == DB_LAST);
    end
  end

  // Per-key debounce counters and accepted levels, plus press pulses for the two mode keys.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_keys_db    <= '0;
      r_next_pulse <= 1'b0;
      r_prev_pulse <= 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        r_db_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (w_key_lvl[k] == r_keys_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (w_db_done[k]) begin
          r_db_cnt[k]  <= '0;
          r_keys_db[k] <= w_key_lvl[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + CW'(1);
        end
      end
      // Only an accepted press (0->1) pulses; accepted releases are silent.
      r_next_pulse <= w_db_done[NEXT_KEY] & w_key_lvl[NEXT_KEY];
      r_prev_pulse <= w_db_done[PREV_KEY] & w_key_lvl[PREV_KEY];
    end
  end

  // Neighbour modes with wrap-around in both directions.
  always_comb begin
    w_step      = r_next_pulse ^ r_prev_pulse;
    w_next_mode = (r_mode == LAST_MODE) ? '0 : (r_mode + MW'(1));
    w_prev_mode = (r_mode == '0) ? LAST_MODE : (r_mode - MW'(1));
    w_pend_en   = NUM_MODES'(1) << r_pending;
    w_pend_leds = LED_W'(1) << r_pending;
  end

  // Select the active mode's slice; constant-indexed loop keeps other slices off the path.
  always_comb begin
    w_sel_row = '0;
    w_sel_col = '0;
    for (int m = 0; m < NUM_MODES; m++) begin
      if (r_mode == MW'(m)) begin
        w_sel_row = mode_row_in[m*ROWS +: ROWS];
        w_sel_col = mode_col_in[m*COLS +: COLS];
      end
    end
  end

  // Mode FSM: RUN forwards the active pattern, BLANK holds everything dark before the switch.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StRun;
      r_mode      <= '0;
      r_pending   <= '0;
      r_blank_cnt <= '0;
      r_enable    <= NUM_MODES'(1);
      r_leds      <= LED_W'(1);
      r_row       <= '0;
      r_col       <= '0;
    end else begin
      unique case (r_state)
        StRun: begin
          if (w_step) begin
            // Simultaneous NEXT and PREV cancel; exactly one of them steps the mode.
            r_pending   <= r_next_pulse ? w_next_mode : w_prev_mode;
            r_state     <= StBlank;
            r_blank_cnt <= '0;
            r_enable    <= '0;
            r_leds      <= '0;
            r_row       <= '0;
            r_col       <= '0;
          end else begin
            r_row <= w_sel_row;
            r_col <= w_sel_col;
          end
        end
        StBlank: begin
          // Pulses arriving here are dropped, not queued.
          if (r_blank_cnt == BLANK_LAST) begin
            r_mode   <= r_pending;
            r_enable <= w_pend_en;
            r_leds   <= w_pend_leds;
            r_state  <= StRun;
          end else begin
            r_blank_cnt <= r_blank_cnt + BW'(1);
          end
        end
        default: begin
          r_state <= StRun;
        end
      endcase
    end
  end

  // Drive the ports straight from registers.
  always_comb begin
    keys_db = r_keys_db;
    enable  = r_enable;
    mode    = r_mode;
    row     = r_row;
    column  = r_col;
    leds    = r_leds;
  end

`ifndef SYNTHESIS
  // Mode indices must never reach NUM_MODES or beyond.
  always_ff @(posedge CLOCK_50) begin
    if (rst_n) begin
      assert (r_mode <= LAST_MODE);
      assert (r_pending <= LAST_MODE);
      assert (w_next_mode <= LAST_MODE);
      assert (w_prev_mode <= LAST_MODE);
    end
  end
`endif

endmodule

// File: tb/tb_matrix_mode_hub.sv
// Randomised bench for matrix_mode_hub with an integer-level reference model and per-cycle compare.
module tb_matrix_mode_hub;

  localparam int ROWS   = 5;
  localparam int COLS   = 7;
  localparam int NK     = 7;
  localparam int NM     = 4;
  localparam int LW     = 8;
  localparam int NEXTK  = 6;
  localparam int PREVK  = 5;
  localparam int DEB    = 4;
  localparam int BLANK  = 3;
  localparam int MW     = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NK-1:0]        keys = '1;
  logic [NM*ROWS-1:0]   mode_row_in = '0;
  logic [NM*COLS-1:0]   mode_col_in = '0;
  logic [NK-1:0]        keys_db;
  logic [NM-1:0]        enable;
  logic [MW-1:0]        mode;
  logic [ROWS-1:0]      row;
  logic [COLS-1:0]      column;
  logic [LW-1:0]        leds;

  int n_total = 0;
  int n_pass  = 0;

  logic [ROWS-1:0] pat_row [NM];
  logic [COLS-1:0] pat_col [NM];

  matrix_mode_hub #(
    .ROWS(ROWS), .COLS(COLS), .NUM_KEYS(NK), .NUM_MODES(NM), .LED_W(LW),
    .NEXT_KEY(NEXTK), .PREV_KEY(PREVK), .DEBOUNCE_CYC(DEB), .BLANK_CYC(BLANK)
  ) dut (
    .CLOCK_50    (clk),
    .rst_n       (rst_n),
    .keys        (keys),
    .mode_row_in (mode_row_in),
    .mode_col_in (mode_col_in),
    .keys_db     (keys_db),
    .enable      (enable),
    .mode        (mode),
    .row         (row),
    .column      (column),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Debouncer sees the pin level two clock edges late; m_run counts consecutive disagreeing cycles.
  bit [NK-1:0]   m_h1, m_h2, m_db;
  int            m_run [NK];
  bit            m_np, m_pp;
  int            m_mode, m_pend, m_blank;
  bit [ROWS-1:0] m_row;
  bit [COLS-1:0] m_col;

  always @(posedge clk or negedge rst_n) begin : model
    bit [NK-1:0] lvl;
    bit np, pp;
    if (!rst_n) begin
      m_h1 = '1; m_h2 = '1; m_db = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
      m_np = 0; m_pp = 0;
      m_mode = 0; m_pend = 0; m_blank = 0;
      m_row = '0; m_col = '0;
    end else begin
      if (m_blank > 0) begin
        m_row = '0; m_col = '0;
        m_blank--;
        if (m_blank == 0) m_mode = m_pend;
      end else if (m_np != m_pp) begin
        m_pend  = m_np ? (m_mode + 1) % NM : (m_mode + NM - 1) % NM;
        m_blank = BLANK;
        m_row = '0; m_col = '0;
      end else begin
        m_row = mode_row_in[m_mode*ROWS +: ROWS];
        m_col = mode_col_in[m_mode*COLS +: COLS];
      end
      lvl = ~m_h2;
      np = 0; pp = 0;
      for (int k = 0; k < NK; k++) begin
        if (lvl[k] != m_db[k]) begin
          if (m_run[k] == DEB - 1) begin
            m_db[k] = lvl[k];
            m_run[k] = 0;
            if (lvl[k] && k == NEXTK) np = 1;
            if (lvl[k] && k == PREVK) pp = 1;
          end else begin
            m_run[k]++;
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_np = np; m_pp = pp;
      m_h2 = m_h1; m_h1 = keys;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [NM-1:0] e_en;
    logic [LW-1:0] e_leds;
    e_en   = (m_blank > 0) ? '0 : NM'(1) << m_mode;
    e_leds = (m_blank > 0) ? '0 : LW'(1) << m_mode;
    check("keys_db", 32'(keys_db), 32'(m_db));
    check("enable",  32'(enable),  32'(e_en));
    check("mode",    32'(mode),    32'(m_mode));
    check("row",     32'(row),     32'(m_row));
    check("column",  32'(column),  32'(m_col));
    check("leds",    32'(leds),    32'(e_leds));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_pat();
    for (int m = 0; m < NM; m++) begin
      mode_row_in[m*ROWS +: ROWS] = pat_row[m];
      mode_col_in[m*COLS +: COLS] = pat_col[m];
    end
  endtask

  task automatic press(input int k);
    keys[k] = 1'b0;
    repeat (12) tick();
    keys[k] = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    logic [COLS-1:0] c;
    for (int m = 0; m < NM; m++) begin
      c = 7'h11;
      pat_row[m] = ROWS'(m + 1);
      pat_col[m] = c << m;
    end
    apply_pat();

    // 1: reset release
    repeat (3) tick();
    rst_n = 1'b1;
    check("rst_enable", 32'(enable), 32'h1);
    check("rst_mode",   32'(mode),   32'h0);
    check("rst_leds",   32'(leds),   32'h01);
    check("rst_row",    32'(row),    32'h0);
    tick();
    check("m0_row", 32'(row),    32'h01);
    check("m0_col", 32'(column), 32'h11);

    // 2: short glitch rejected, then a real NEXT press with exact timing
    keys[NEXTK] = 1'b0;
    repeat (3) tick();
    keys[NEXTK] = 1'b1;
    repeat (8) tick();
    check("glitch_db",   32'(keys_db), 32'h0);
    check("glitch_mode", 32'(mode),    32'h0);
    keys[NEXTK] = 1'b0;
    repeat (5) tick();
    check("db_before_6", 32'(keys_db[NEXTK]), 32'h0);
    tick();
    check("db_at_6", 32'(keys_db[NEXTK]), 32'h1);
    for (int i = 0; i < BLANK; i++) begin
      tick();
      check("blank_enable", 32'(enable), 32'h0);
      check("blank_row",    32'(row),    32'h0);
      check("blank_leds",   32'(leds),   32'h0);
    end
    tick();
    check("sw_enable", 32'(enable), 32'h2);
    check("sw_mode",   32'(mode),   32'h1);
    check("sw_leds",   32'(leds),   32'h02);
    tick();
    check("m1_row", 32'(row),    32'h02);
    check("m1_col", 32'(column), 32'h22);
    keys[NEXTK] = 1'b1;
    repeat (8) tick();
    check("release_no_step", 32'(mode), 32'h1);

    // 3: wrap in both directions
    press(PREVK);
    check("prev_1_to_0", 32'(mode), 32'h0);
    press(PREVK);
    check("wrap_prev_mode",   32'(mode),   32'h3);
    check("wrap_prev_enable", 32'(enable), 32'h8);
    check("wrap_prev_leds",   32'(leds),   32'h08);
    press(NEXTK);
    check("wrap_next_mode",   32'(mode),   32'h0);
    check("wrap_next_enable", 32'(enable), 32'h1);

    // 4: simultaneous presses cancel; a press landing in BLANK is dropped
    keys[NEXTK] = 1'b0;
    keys[PREVK] = 1'b0;
    repeat (12) tick();
    check("both_mode",   32'(mode),   32'h0);
    check("both_enable", 32'(enable), 32'h1);
    keys[NEXTK] = 1'b1;
    keys[PREVK] = 1'b1;
    repeat (8) tick();
    keys[NEXTK] = 1'b0;
    repeat (2) tick();
    keys[PREVK] = 1'b0;
    repeat (12) tick();
    keys[NEXTK] = 1'b1;
    keys[PREVK] = 1'b1;
    repeat (8) tick();
    check("blank_drop_mode", 32'(mode), 32'h1);

    // 5: reset in the middle of BLANK
    keys[NEXTK] = 1'b0;
    repeat (8) tick();
    check("pre_rst_enable", 32'(enable), 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_mode",    32'(mode),    32'h0);
    check("midrst_enable",  32'(enable),  32'h1);
    check("midrst_row",     32'(row),     32'h0);
    check("midrst_col",     32'(column),  32'h0);
    check("midrst_keys_db", 32'(keys_db), 32'h0);
    check("midrst_leds",    32'(leds),    32'h01);
    keys[NEXTK] = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check("pending_discarded", 32'(mode), 32'h0);

    // 6: cycle all modes with distinct patterns
    for (int m = 1; m <= NM; m++) begin
      press(NEXTK);
      check("cyc_mode", 32'(mode),   32'(m % NM));
      check("cyc_row",  32'(row),    32'(pat_row[m % NM]));
      check("cyc_col",  32'(column), 32'(pat_col[m % NM]));
    end
    for (int m = 1; m < NM; m++) begin
      pat_row[m] = ROWS'($urandom);
      pat_col[m] = COLS'($urandom);
    end
    apply_pat();
    repeat (2) tick();
    check("inactive_row", 32'(row),    32'h01);
    check("inactive_col", 32'(column), 32'h11);

    // Randomised phase: the per-cycle compare covers it.
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          for (int m = 0; m < NM; m++) begin
            pat_row[m] = ROWS'($urandom);
            pat_col[m] = COLS'($urandom);
          end
          apply_pat();
        end
        1: begin
          keys[NEXTK] = 1'b0;
          repeat ($urandom_range(1, 10)) tick();
          keys[NEXTK] = 1'b1;
        end
        2: begin
          keys[PREVK] = 1'b0;
          repeat ($urandom_range(1, 10)) tick();
          keys[PREVK] = 1'b1;
        end
        default: begin
          keys[4:0] = 5'($urandom);
        end
      endcase
      repeat ($urandom_range(0, 8)) tick();
    end
    keys = '1;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
